// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: operand select, ALU, data SRAM
// request, forwarding bus to decode, and a 32-step restoring divider owning HI/LO.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_rf_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex,
    output logic [1:0]   div_state_dbg
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Handshake: stallreq_for_ex is this stage's request to freeze the front of the
    // pipe; the stall vector is the grant. stall[2] Stop with stall[3] running
    // injects a bubble, both stopped holds id_r, stall[2] running loads a new op.
    logic [158:0] id_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_r <= '0;
        end else if (stall[2] == STOP && stall[3] != STOP) begin
            id_r <= '0;
        end else if (stall[2] != STOP) begin
            id_r <= id_to_ex_bus;
        end
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en, rf_we, sel_rf_res;
    logic [3:0]  data_ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_r;

    logic unused_ok;
    assign unused_ok = ^{inst[25:16], stall[5:4], stall[1:0]};

    logic [31:0] src1, src2, alu_result;

    always_comb begin
        src1 = '0;
        if (sel_alu_src1[0])      src1 = rdata1;
        else if (sel_alu_src1[1]) src1 = pc;
        else if (sel_alu_src1[2]) src1 = {27'b0, inst[10:6]};
    end

    always_comb begin
        src2 = '0;
        if (sel_alu_src2[0])      src2 = rdata2;
        else if (sel_alu_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
        else if (sel_alu_src2[2]) src2 = 32'd8;
        else if (sel_alu_src2[3]) src2 = {16'b0, inst[15:0]};
    end

    // alu_op is one-hot, MSB = add down to LSB = lui
    always_comb begin
        alu_result = '0;
        if (alu_op[11])     alu_result = src1 + src2;
        else if (alu_op[10]) alu_result = src1 - src2;
        else if (alu_op[9])  alu_result = {31'b0, $signed(src1) < $signed(src2)};
        else if (alu_op[8])  alu_result = {31'b0, src1 < src2};
        else if (alu_op[7])  alu_result = src1 & src2;
        else if (alu_op[6])  alu_result = ~(src1 | src2);
        else if (alu_op[5])  alu_result = src1 | src2;
        else if (alu_op[4])  alu_result = src1 ^ src2;
        else if (alu_op[3])  alu_result = src2 << src1[4:0];
        else if (alu_op[2])  alu_result = src2 >> src1[4:0];
        else if (alu_op[1])  alu_result = $signed(src2) >>> src1[4:0];
        else if (alu_op[0])  alu_result = {src2[15:0], 16'b0};
    end

    logic is_special, op_mfhi, op_mflo, op_mthi, op_mtlo, op_div, op_divu, op_anydiv;
    assign is_special = (inst[31:26] == 6'b000000);
    assign op_mfhi    = is_special && (inst[5:0] == 6'b010000);
    assign op_mthi    = is_special && (inst[5:0] == 6'b010001);
    assign op_mflo    = is_special && (inst[5:0] == 6'b010010);
    assign op_mtlo    = is_special && (inst[5:0] == 6'b010011);
    assign op_div     = is_special && (inst[5:0] == 6'b011010);
    assign op_divu    = is_special && (inst[5:0] == 6'b011011);
    assign op_anydiv  = op_div || op_divu;

    div_state_t  state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [63:0] div_reg, div_reg_n;
    logic [31:0] divisor, divisor_n;
    logic        neg_q, neg_r, neg_q_n, neg_r_n;
    logic [31:0] hi, lo;

    logic [31:0] dividend_abs, divisor_abs;
    assign dividend_abs = (op_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
    assign divisor_abs  = (op_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;

    // div_reg holds {remainder, quotient}; each step shifts one dividend bit in
    logic [32:0] partial, diff;
    assign partial = div_reg[63:31];
    assign diff    = partial - {1'b0, divisor};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_reg_n = div_reg;
        divisor_n = divisor;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        case (state)
            DIV_IDLE: begin
                if (op_anydiv) begin
                    cnt_n     = 6'd0;
                    divisor_n = divisor_abs;
                    if (rdata2 == 32'd0) begin
                        div_reg_n = {rdata1, 32'hFFFF_FFFF};
                        neg_q_n   = 1'b0;
                        neg_r_n   = 1'b0;
                        state_n   = DIV_DONE;
                    end else begin
                        div_reg_n = {32'd0, dividend_abs};
                        neg_q_n   = op_div && (rdata1[31] ^ rdata2[31]);
                        neg_r_n   = op_div && rdata1[31];
                        state_n   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (!diff[32]) div_reg_n = {diff[31:0], div_reg[30:0], 1'b1};
                else           div_reg_n = {partial[31:0], div_reg[30:0], 1'b0};
                cnt_n = cnt + 6'd1;
                if (cnt == 6'd31) state_n = DIV_DONE;
            end
            DIV_DONE: begin
                if (stall[2] != STOP) state_n = DIV_IDLE;
            end
            default: state_n = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            div_reg <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_reg <= div_reg_n;
            divisor <= divisor_n;
            neg_q   <= neg_q_n;
            neg_r   <= neg_r_n;
        end
    end

    logic [31:0] quo_fix, rem_fix;
    assign quo_fix = neg_q ? (32'd0 - div_reg[31:0])  : div_reg[31:0];
    assign rem_fix = neg_r ? (32'd0 - div_reg[63:32]) : div_reg[63:32];

    // A DONE write and MTHI/MTLO cannot coincide: both need their own op in id_r
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (stall[2] != STOP) begin
            if (state == DIV_DONE) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                if (op_mthi) hi <= rdata1;
                if (op_mtlo) lo <= rdata1;
            end
        end
    end

    logic [31:0] ex_result;
    assign ex_result = op_mfhi ? hi : (op_mflo ? lo : alu_result);

    assign stallreq_for_ex = op_anydiv && (state != DIV_DONE);
    assign div_state_dbg   = state;

    assign data_sram_en    = data_ram_en;
    assign data_sram_wen   = data_ram_wen;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rdata2;

    assign ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: mnemonic-level stimulus encoded like decode would, checked
// against an instruction-semantics model with HI/LO kept as plain variables.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [5:0]   stall_drv;
    logic         auto_stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;
    logic [1:0]   div_state_dbg;

    always #5 clk = ~clk;

    // Pipeline stall controller: a divide request freezes stages 0..3.
    assign stall = (auto_stall && stallreq_for_ex) ? 6'b001111 : stall_drv;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .id_to_ex_bus   (id_to_ex_bus),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_to_rf_bus   (ex_to_rf_bus),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .stallreq_for_ex(stallreq_for_ex),
        .div_state_dbg  (div_state_dbg)
    );

    typedef enum int {
        M_ADDU, M_SUBU, M_SLT, M_SLTU, M_AND, M_NOR, M_OR, M_XOR,
        M_SLL, M_SRL, M_SRA, M_ADDIU, M_SLTI, M_ORI, M_LUI, M_LW, M_SW, M_JAL,
        M_MFHI, M_MFLO, M_MTHI, M_MTLO, M_DIV, M_DIVU
    } mn_t;

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                            OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                            OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                            OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

    int checks = 0;
    int failures = 0;
    logic [75:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Encode a mnemonic the way the decode stage fills the bus.
    function automatic logic [158:0] encode(input mn_t mn, input logic [31:0] pc,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [4:0] rd, input logic [4:0] sa,
                                            input logic [15:0] imm);
        logic [5:0] opc, fn;
        logic [11:0] op;
        logic [2:0] s1;
        logic [3:0] s2, wen;
        logic ren, we, rsel, itype;
        logic [4:0] wa;
        logic [31:0] inst;
        opc = 6'd0; fn = 6'd0; op = 12'd0; s1 = 3'b001; s2 = 4'b0001;
        ren = 1'b0; wen = 4'd0; we = 1'b1; rsel = 1'b0; itype = 1'b0; wa = rd;
        case (mn)
            M_ADDU:  begin fn = 6'h21; op = OP_ADD;  end
            M_SUBU:  begin fn = 6'h23; op = OP_SUB;  end
            M_SLT:   begin fn = 6'h2A; op = OP_SLT;  end
            M_SLTU:  begin fn = 6'h2B; op = OP_SLTU; end
            M_AND:   begin fn = 6'h24; op = OP_AND;  end
            M_NOR:   begin fn = 6'h27; op = OP_NOR;  end
            M_OR:    begin fn = 6'h25; op = OP_OR;   end
            M_XOR:   begin fn = 6'h26; op = OP_XOR;  end
            M_SLL:   begin fn = 6'h00; op = OP_SLL; s1 = 3'b100; end
            M_SRL:   begin fn = 6'h02; op = OP_SRL; s1 = 3'b100; end
            M_SRA:   begin fn = 6'h03; op = OP_SRA; s1 = 3'b100; end
            M_ADDIU: begin opc = 6'h09; itype = 1'b1; op = OP_ADD; s2 = 4'b0010; end
            M_SLTI:  begin opc = 6'h0A; itype = 1'b1; op = OP_SLT; s2 = 4'b0010; end
            M_ORI:   begin opc = 6'h0D; itype = 1'b1; op = OP_OR;  s2 = 4'b1000; end
            M_LUI:   begin opc = 6'h0F; itype = 1'b1; op = OP_LUI; s1 = 3'b000; s2 = 4'b0010; end
            M_LW:    begin opc = 6'h23; itype = 1'b1; op = OP_ADD; s2 = 4'b0010; ren = 1'b1; rsel = 1'b1; end
            M_SW:    begin opc = 6'h2B; itype = 1'b1; op = OP_ADD; s2 = 4'b0010; ren = 1'b1; wen = 4'hF; we = 1'b0; end
            M_JAL:   begin opc = 6'h03; itype = 1'b1; op = OP_ADD; s1 = 3'b010; s2 = 4'b0100; wa = 5'd31; end
            M_MFHI:  begin fn = 6'h10; s1 = 3'b000; s2 = 4'b0000; end
            M_MFLO:  begin fn = 6'h12; s1 = 3'b000; s2 = 4'b0000; end
            M_MTHI:  begin fn = 6'h11; s1 = 3'b000; s2 = 4'b0000; we = 1'b0; end
            M_MTLO:  begin fn = 6'h13; s1 = 3'b000; s2 = 4'b0000; we = 1'b0; end
            M_DIV:   begin fn = 6'h1A; s1 = 3'b000; s2 = 4'b0000; we = 1'b0; end
            M_DIVU:  begin fn = 6'h1B; s1 = 3'b000; s2 = 4'b0000; we = 1'b0; end
            default: ;
        endcase
        if (itype && mn != M_JAL) wa = 5'd2;
        inst = itype ? {opc, 5'd1, 5'd2, imm} : {6'd0, 5'd1, 5'd2, rd, sa, fn};
        return {pc, inst, op, s1, s2, ren, wen, we, wa, rsel, rs, rt};
    endfunction

    // Architectural result of each mnemonic.
    function automatic logic [31:0] model_result(input mn_t mn, input logic [31:0] pc,
                                                 input logic [31:0] rs, input logic [31:0] rt,
                                                 input logic [4:0] sa, input logic [15:0] imm);
        logic [31:0] sx, zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'd0, imm};
        case (mn)
            M_ADDU:  return rs + rt;
            M_SUBU:  return rs - rt;
            M_SLT:   return {31'd0, $signed(rs) < $signed(rt)};
            M_SLTU:  return {31'd0, rs < rt};
            M_AND:   return rs & rt;
            M_NOR:   return ~(rs | rt);
            M_OR:    return rs | rt;
            M_XOR:   return rs ^ rt;
            M_SLL:   return rt << sa;
            M_SRL:   return rt >> sa;
            M_SRA:   return $signed(rt) >>> sa;
            M_ADDIU: return rs + sx;
            M_SLTI:  return {31'd0, $signed(rs) < $signed(sx)};
            M_ORI:   return rs | zx;
            M_LUI:   return {imm, 16'd0};
            M_LW:    return rs + sx;
            M_SW:    return rs + sx;
            M_JAL:   return pc + 32'd8;
            M_MFHI:  return m_hi;
            M_MFLO:  return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one instruction at a negedge, check its outputs one edge later.
    task automatic issue(input mn_t mn, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sa, input logic [15:0] imm,
                         output logic [75:0] exp_bus);
        logic [158:0] b;
        logic [31:0] pc, res;
        pc  = $urandom;
        b   = encode(mn, pc, rs, rt, 5'($urandom_range(1, 30)), sa, imm);
        res = model_result(mn, pc, rs, rt, sa, imm);
        exp_bus = {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res};
        exp_q.push_back(exp_bus);
        id_to_ex_bus = b;
        @(posedge clk); #1;
        check("ex_to_mem_bus", ex_to_mem_bus, exp_q.pop_front());
        check("ex_to_rf_bus", ex_to_rf_bus, {b[70], b[69:65], res});
        check("sram_en_wen", {data_sram_en, data_sram_wen}, {b[75], b[74:71]});
        check("sram_wdata", data_sram_wdata, rt);
        if (mn == M_LW || mn == M_SW) check("sram_addr", data_sram_addr, rs + {{16{imm[15]}}, imm});
        if (mn == M_MTHI) m_hi = rs;
        if (mn == M_MTLO) m_lo = rs;
        @(negedge clk);
    endtask

    task automatic do_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] eq, er;
        longint sa64, sb64, q64, r64;
        logic [75:0] e;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a;
        end else if (is_signed) begin
            sa64 = longint'($signed(a)); sb64 = longint'($signed(b));
            q64 = sa64 / sb64; r64 = sa64 % sb64;
            eq = q64[31:0]; er = r64[31:0];
        end else begin
            eq = a / b; er = a % b;
        end
        id_to_ex_bus = encode(is_signed ? M_DIV : M_DIVU, $urandom, a, b, 5'd0, 5'd0, 16'd0);
        @(posedge clk); #1;
        // MFLO waits on the bus while EX is frozen
        id_to_ex_bus = encode(M_MFLO, $urandom, 32'd0, 32'd0, 5'd3, 5'd0, 16'd0);
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("div_stall_cycles", n, (b == 32'd0) ? 1 : 33);
        @(posedge clk); #1;
        m_hi = er;
        m_lo = eq;
        check("mflo_after_div", ex_to_rf_bus[31:0], eq);
        @(negedge clk);
        issue(M_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        logic [75:0] e, held;
        logic [159:0] junk;
        mn_t mn;
        rst = 1'b0;
        stall_drv = 6'd0;
        auto_stall = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
        id_to_ex_bus = junk[158:0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_bus", ex_to_mem_bus, 76'd0);
        check("reset_rf_bus", ex_to_rf_bus, 38'd0);
        check("reset_stallreq", stallreq_for_ex, 1'b0);
        check("reset_sram_en", data_sram_en, 1'b0);
        check("reset_fsm_idle", div_state_dbg, 2'd0);
        rst = 1'b1;

        issue(M_ORI, 32'h0000_1200, 32'd0, 5'd0, 16'h0034, e);
        check("ori_result", ex_to_rf_bus[31:0], 32'h0000_1234);
        check("ori_rf_we", ex_to_rf_bus[37], 1'b1);
        issue(M_ADDIU, 32'd5, 32'd0, 5'd0, 16'hFFFF, e);
        check("addiu_result", ex_to_rf_bus[31:0], 32'h0000_0004);
        issue(M_LUI, 32'd0, 32'd0, 5'd0, 16'hABCD, e);
        check("lui_result", ex_to_rf_bus[31:0], 32'hABCD_0000);

        // Bubble: EX stopped while MEM runs
        id_to_ex_bus = encode(M_ADDU, $urandom, 32'd7, 32'd9, 5'd4, 5'd0, 16'd0);
        stall_drv = 6'b000100;
        @(posedge clk); #1;
        check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
        check("bubble_stallreq", stallreq_for_ex, 1'b0);
        @(negedge clk);
        stall_drv = 6'd0;

        // Hold: EX and MEM both stopped
        issue(M_SW, 32'h1000_0000, 32'hDEAD_BEEF, 5'd0, 16'h0010, held);
        id_to_ex_bus = encode(M_XOR, $urandom, 32'h5, 32'h3, 5'd6, 5'd0, 16'd0);
        stall_drv = 6'b001100;
        @(posedge clk); #1;
        check("hold_mem_bus", ex_to_mem_bus, held);
        @(negedge clk);
        stall_drv = 6'd0;

        do_div(1'b0, 32'd100, 32'd7);
        check("divu_lo_14", m_lo, 32'd14);
        check("divu_hi_2", m_hi, 32'd2);
        do_div(1'b0, 32'd9, 32'd0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", m_lo, 32'hFFFF_FFFD);
        issue(M_MFLO, 32'd0, 32'd0, 5'd0, 16'd0, e);

        issue(M_MTHI, 32'h1234_5678, 32'd0, 5'd0, 16'd0, e);
        issue(M_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, e);
        issue(M_MTLO, 32'h8765_4321, 32'd0, 5'd0, 16'd0, e);
        issue(M_MFLO, 32'd0, 32'd0, 5'd0, 16'd0, e);

        for (int i = 0; i < 80; i++) begin
            mn = mn_t'($urandom_range(0, 21));
            issue(mn, $urandom, $urandom, 5'($urandom_range(0, 31)), 16'($urandom), e);
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            do_div(1'($urandom_range(0, 1)), a, b);
        end

        // Make HI/LO nonzero, then reset in the middle of a division
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        id_to_ex_bus = encode(M_DIVU, $urandom, 32'd1000, 32'd3, 5'd0, 5'd0, 16'd0);
        @(posedge clk); #1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("busy_before_reset", div_state_dbg, 2'd1);
        check("stall_before_reset", stallreq_for_ex, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        id_to_ex_bus = '0;
        @(posedge clk); #1;
        check("reset_mid_div_stallreq", stallreq_for_ex, 1'b0);
        check("reset_mid_div_idle", div_state_dbg, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        issue(M_MFHI, 32'd0, 32'd0, 5'd0, 16'd0, e);
        issue(M_MFLO, 32'd0, 32'd0, 5'd0, 16'd0, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
